// File: rtl/ctrl_pipeline.sv
// rtl/ctrl_pipeline.sv - EX/MEM/WB control pipeline with load-use stall, flush bubbles and forwarding select
module ctrl_pipeline (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [8:0] id_ctrl,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [4:0] id_rd,
  input  logic       flush,
  output logic       stall,
  output logic [8:0] ex_ctrl,
  output logic [3:0] mem_ctrl,
  output logic [1:0] wb_ctrl,
  output logic [4:0] ex_rd,
  output logic [4:0] mem_rd,
  output logic [4:0] wb_rd,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  localparam int unsigned REGWRITE = 8;
  localparam int unsigned MEMREAD  = 7;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  logic [8:0] ex_ctrl_q,  ex_ctrl_d;
  logic       ex_valid_q, ex_valid_d;
  logic [4:0] ex_rd_q,    ex_rd_d;
  logic [4:0] ex_rs1_q,   ex_rs1_d;
  logic [4:0] ex_rs2_q,   ex_rs2_d;

  logic [3:0] mem_ctrl_q,  mem_ctrl_d;
  logic       mem_valid_q, mem_valid_d;
  logic [4:0] mem_rd_q,    mem_rd_d;

  logic [1:0] wb_ctrl_q,  wb_ctrl_d;
  logic       wb_valid_q, wb_valid_d;
  logic [4:0] wb_rd_q,    wb_rd_d;

  logic load_use;
  logic bubble;
  logic mem_fwd_ok;
  logic wb_fwd_ok;

  // Hazard detection: the load in EX cannot supply its data until WB.
  always_comb begin
    load_use = ex_valid_q && ex_ctrl_q[MEMREAD] && (ex_rd_q != 5'd0) && id_valid &&
               ((ex_rd_q == id_rs1) || (ex_rd_q == id_rs2));
    stall    = load_use && !flush;
    bubble   = flush || load_use || !id_valid;
  end

  always_comb begin
    ex_ctrl_d  = 9'd0;
    ex_valid_d = 1'b0;
    ex_rd_d    = 5'd0;
    ex_rs1_d   = 5'd0;
    ex_rs2_d   = 5'd0;
    if (!bubble) begin
      ex_ctrl_d  = id_ctrl;
      ex_valid_d = 1'b1;
      ex_rd_d    = id_rd;
      ex_rs1_d   = id_rs1;
      ex_rs2_d   = id_rs2;
      // x0 is hardwired; dropping the write here keeps it out of forwarding too.
      if (id_rd == 5'd0) begin
        ex_ctrl_d[REGWRITE] = 1'b0;
      end
    end
  end

  always_comb begin
    mem_ctrl_d  = ex_ctrl_q[8:5];
    mem_valid_d = ex_valid_q;
    mem_rd_d    = ex_rd_q;
    wb_ctrl_d   = {mem_ctrl_q[3], mem_ctrl_q[0]};
    wb_valid_d  = mem_valid_q;
    wb_rd_d     = mem_rd_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_ctrl_q   <= 9'd0;
      ex_valid_q  <= 1'b0;
      ex_rd_q     <= 5'd0;
      ex_rs1_q    <= 5'd0;
      ex_rs2_q    <= 5'd0;
      mem_ctrl_q  <= 4'd0;
      mem_valid_q <= 1'b0;
      mem_rd_q    <= 5'd0;
      wb_ctrl_q   <= 2'd0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= 5'd0;
    end else begin
      ex_ctrl_q   <= ex_ctrl_d;
      ex_valid_q  <= ex_valid_d;
      ex_rd_q     <= ex_rd_d;
      ex_rs1_q    <= ex_rs1_d;
      ex_rs2_q    <= ex_rs2_d;
      mem_ctrl_q  <= mem_ctrl_d;
      mem_valid_q <= mem_valid_d;
      mem_rd_q    <= mem_rd_d;
      wb_ctrl_q   <= wb_ctrl_d;
      wb_valid_q  <= wb_valid_d;
      wb_rd_q     <= wb_rd_d;
    end
  end

  // Operand forwarding looks only at stage registers; the younger MEM result wins.
  always_comb begin
    mem_fwd_ok = mem_valid_q && mem_ctrl_q[3] && (mem_rd_q != 5'd0);
    wb_fwd_ok  = wb_valid_q && wb_ctrl_q[1] && (wb_rd_q != 5'd0);

    fwd_a = FWD_RF;
    if (mem_fwd_ok && (mem_rd_q == ex_rs1_q)) begin
      fwd_a = FWD_MEM;
    end else if (wb_fwd_ok && (wb_rd_q == ex_rs1_q)) begin
      fwd_a = FWD_WB;
    end

    fwd_b = FWD_RF;
    if (mem_fwd_ok && (mem_rd_q == ex_rs2_q)) begin
      fwd_b = FWD_MEM;
    end else if (wb_fwd_ok && (wb_rd_q == ex_rs2_q)) begin
      fwd_b = FWD_WB;
    end
  end

  assign ex_ctrl  = ex_ctrl_q;
  assign mem_ctrl = mem_ctrl_q;
  assign wb_ctrl  = wb_ctrl_q;
  assign ex_rd    = ex_rd_q;
  assign mem_rd   = mem_rd_q;
  assign wb_rd    = wb_rd_q;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// tb/tb_ctrl_pipeline.sv - scoreboard bench for ctrl_pipeline
module tb_ctrl_pipeline;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [8:0] id_ctrl = 9'd0;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs1 = 5'd0;
  logic [4:0] id_rs2 = 5'd0;
  logic [4:0] id_rd = 5'd0;
  logic       flush = 1'b0;
  logic       stall;
  logic [8:0] ex_ctrl;
  logic [3:0] mem_ctrl;
  logic [1:0] wb_ctrl;
  logic [4:0] ex_rd, mem_rd, wb_rd;
  logic [1:0] fwd_a, fwd_b;

  localparam logic [8:0] C_ADD  = 9'h102;
  localparam logic [8:0] C_ADDI = 9'h110;
  localparam logic [8:0] C_LW   = 9'h1B0;
  localparam logic [8:0] C_SW   = 9'h050;

  ctrl_pipeline dut (
    .clk(clk), .rst_n(rst_n), .id_ctrl(id_ctrl), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .flush(flush),
    .stall(stall), .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd), .fwd_a(fwd_a), .fwd_b(fwd_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    int         due;
    logic [1:0] ctrl;
    logic [4:0] rd;
  } sb_t;
  sb_t sb[$];

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (sb.size() > 0 && sb[0].due <= cyc) begin
        n_checks++;
        if (sb[0].due != cyc || wb_ctrl !== sb[0].ctrl || wb_rd !== sb[0].rd) begin
          n_fails++;
          $display("FAIL sb_wb cyc=%0d due=%0d: wb_ctrl=%b wb_rd=%0d, required wb_ctrl=%b wb_rd=%0d",
                   cyc, sb[0].due, wb_ctrl, wb_rd, sb[0].ctrl, sb[0].rd);
        end
        sb.delete(0);
      end else begin
        n_checks++;
        if (wb_ctrl !== 2'b00) begin
          n_fails++;
          $display("FAIL sb_wb_idle cyc=%0d: wb_ctrl=%b, required 00", cyc, wb_ctrl);
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [8:0] c, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2);
    id_valid = v;
    id_ctrl  = c;
    id_rd    = rd;
    id_rs1   = rs1;
    id_rs2   = rs2;
  endtask

  task automatic push(input logic [8:0] c, input logic [4:0] rd);
    sb_t e;
    e.due  = cyc + 3;
    e.ctrl = {c[8] & (rd != 5'd0), c[5]};
    e.rd   = rd;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    drive(1'b0, 9'd0, 5'd0, 5'd0, 5'd0);
    repeat (n) cycle();
  endtask

  task automatic test_reset();
    drive(1'b1, C_LW, 5'd3, 5'd3, 5'd3);
    repeat (2) cycle();
    n_checks++; if (stall !== 1'b0) begin n_fails++; $display("FAIL rst_stall: got %b, required 0", stall); end
    n_checks++; if (ex_ctrl !== 9'd0) begin n_fails++; $display("FAIL rst_ex_ctrl: got %h, required 000", ex_ctrl); end
    n_checks++; if ({mem_ctrl, wb_ctrl} !== 6'd0) begin n_fails++; $display("FAIL rst_mem_wb_ctrl: got %b, required 000000", {mem_ctrl, wb_ctrl}); end
    n_checks++; if ({ex_rd, mem_rd, wb_rd} !== 15'd0) begin n_fails++; $display("FAIL rst_rd: got %h, required 0", {ex_rd, mem_rd, wb_rd}); end
    n_checks++; if ({fwd_a, fwd_b} !== 4'd0) begin n_fails++; $display("FAIL rst_fwd: got %b, required 0000", {fwd_a, fwd_b}); end
    drive(1'b0, 9'd0, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    n_checks++; if (ex_ctrl !== 9'd0) begin n_fails++; $display("FAIL rst_release_ex: got %h, required 000", ex_ctrl); end
  endtask

  task automatic test_flow();
    drive(1'b1, C_ADD, 5'd5, 5'd1, 5'd2);
    push(C_ADD, 5'd5);
    cycle();
    n_checks++; if (ex_ctrl !== 9'h102 || ex_rd !== 5'd5) begin n_fails++; $display("FAIL flow_ex: got %h rd %0d, required 102 rd 5", ex_ctrl, ex_rd); end
    drive(1'b0, 9'd0, 5'd0, 5'd0, 5'd0);
    cycle();
    n_checks++; if (mem_ctrl !== 4'b1000 || mem_rd !== 5'd5) begin n_fails++; $display("FAIL flow_mem: got %b rd %0d, required 1000 rd 5", mem_ctrl, mem_rd); end
    cycle();
    n_checks++; if (wb_ctrl !== 2'b10 || wb_rd !== 5'd5) begin n_fails++; $display("FAIL flow_wb: got %b rd %0d, required 10 rd 5", wb_ctrl, wb_rd); end
    idle(2);
  endtask

  task automatic test_load_use();
    drive(1'b1, C_LW, 5'd3, 5'd1, 5'd1);
    push(C_LW, 5'd3);
    cycle();
    drive(1'b1, C_ADD, 5'd4, 5'd3, 5'd1);
    #1;
    n_checks++; if (stall !== 1'b1) begin n_fails++; $display("FAIL lu_stall: got %b, required 1", stall); end
    cycle();
    n_checks++; if (ex_ctrl !== 9'd0 || ex_rd !== 5'd0) begin n_fails++; $display("FAIL lu_bubble: got %h rd %0d, required 000 rd 0", ex_ctrl, ex_rd); end
    n_checks++; if (mem_ctrl !== 4'b1101) begin n_fails++; $display("FAIL lu_mem_lw: got %b, required 1101", mem_ctrl); end
    n_checks++; if (stall !== 1'b0) begin n_fails++; $display("FAIL lu_stall_drop: got %b, required 0", stall); end
    push(C_ADD, 5'd4);
    cycle();
    n_checks++; if (ex_ctrl !== 9'h102 || ex_rd !== 5'd4) begin n_fails++; $display("FAIL lu_add_ex: got %h rd %0d, required 102 rd 4", ex_ctrl, ex_rd); end
    n_checks++; if (fwd_a !== 2'b01 || fwd_b !== 2'b00) begin n_fails++; $display("FAIL lu_fwd: got a=%b b=%b, required a=01 b=00", fwd_a, fwd_b); end
    idle(4);
  endtask

  task automatic test_fwd_priority();
    drive(1'b1, C_ADDI, 5'd2, 5'd1, 5'd0); push(C_ADDI, 5'd2); cycle();
    drive(1'b1, C_ADD,  5'd2, 5'd1, 5'd1); push(C_ADD, 5'd2);  cycle();
    drive(1'b1, C_ADD,  5'd6, 5'd2, 5'd2); push(C_ADD, 5'd6);  cycle();
    n_checks++; if (fwd_a !== 2'b10 || fwd_b !== 2'b10) begin n_fails++; $display("FAIL fwd_mem_wins: got a=%b b=%b, required 10 10", fwd_a, fwd_b); end
    idle(4);
    drive(1'b1, C_ADDI, 5'd2, 5'd1, 5'd0); push(C_ADDI, 5'd2); cycle();
    drive(1'b0, 9'd0, 5'd0, 5'd0, 5'd0); cycle();
    drive(1'b1, C_ADD,  5'd6, 5'd2, 5'd2); push(C_ADD, 5'd6);  cycle();
    n_checks++; if (fwd_a !== 2'b01 || fwd_b !== 2'b01) begin n_fails++; $display("FAIL fwd_wb_nop: got a=%b b=%b, required 01 01", fwd_a, fwd_b); end
    idle(4);
  endtask

  task automatic test_store();
    drive(1'b1, C_ADD, 5'd5, 5'd1, 5'd1); push(C_ADD, 5'd5); cycle();
    drive(1'b1, C_SW, 5'd9, 5'd1, 5'd5);
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fails++; $display("FAIL st_no_stall: got %b, required 0", stall); end
    push(C_SW, 5'd9);
    cycle();
    n_checks++; if (fwd_a !== 2'b00 || fwd_b !== 2'b10) begin n_fails++; $display("FAIL st_fwd: got a=%b b=%b, required 00 10", fwd_a, fwd_b); end
    drive(1'b1, C_ADD, 5'd10, 5'd9, 5'd9); push(C_ADD, 5'd10); cycle();
    n_checks++; if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin n_fails++; $display("FAIL st_no_fwd_from_store: got a=%b b=%b, required 00 00", fwd_a, fwd_b); end
    idle(4);
  endtask

  task automatic test_flush_hazard();
    drive(1'b1, C_LW, 5'd3, 5'd1, 5'd1); push(C_LW, 5'd3); cycle();
    drive(1'b1, C_ADD, 5'd4, 5'd3, 5'd0);
    flush = 1'b1;
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fails++; $display("FAIL fl_stall: got %b, required 0", stall); end
    cycle();
    flush = 1'b0;
    n_checks++; if (ex_ctrl !== 9'd0) begin n_fails++; $display("FAIL fl_bubble: got %h, required 000", ex_ctrl); end
    drive(1'b1, C_ADD, 5'd9, 5'd1, 5'd2);
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fails++; $display("FAIL fl_no_second: got %b, required 0", stall); end
    push(C_ADD, 5'd9);
    cycle();
    n_checks++; if (ex_ctrl !== 9'h102 || ex_rd !== 5'd9) begin n_fails++; $display("FAIL fl_next_ex: got %h rd %0d, required 102 rd 9", ex_ctrl, ex_rd); end
    idle(4);
  endtask

  task automatic test_x0();
    drive(1'b1, C_ADDI, 5'd0, 5'd0, 5'd0); push(C_ADDI, 5'd0); cycle();
    n_checks++; if (ex_ctrl !== 9'h010) begin n_fails++; $display("FAIL x0_ex_rw: got %h, required 010", ex_ctrl); end
    drive(1'b1, C_ADD, 5'd7, 5'd0, 5'd0); push(C_ADD, 5'd7); cycle();
    n_checks++; if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin n_fails++; $display("FAIL x0_fwd: got a=%b b=%b, required 00 00", fwd_a, fwd_b); end
    n_checks++; if (mem_ctrl[3] !== 1'b0) begin n_fails++; $display("FAIL x0_mem_rw: got %b, required 0", mem_ctrl[3]); end
    idle(4);
  endtask

  task automatic test_back_to_back();
    logic       m_rw, w_rw;
    logic [4:0] m_rd, w_rd;
    logic       v, st, rw;
    logic [4:0] rd, rs1, rs2;
    logic [8:0] c;
    logic [1:0] ea, eb;
    m_rw = 1'b0; w_rw = 1'b0; m_rd = 5'd0; w_rd = 5'd0;
    for (int i = 0; i < 40; i++) begin
      v   = ($urandom_range(0, 7) != 0);
      st  = ($urandom_range(0, 3) == 0);
      rd  = 5'($urandom_range(0, 7));
      rs1 = 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 7));
      c   = st ? C_SW : C_ADD;
      drive(v, c, rd, rs1, rs2);
      if (v) push(c, rd);
      rw = v && !st && (rd != 5'd0);
      cycle();
      if (v) begin
        ea = (m_rw && m_rd == rs1) ? 2'b10 : (w_rw && w_rd == rs1) ? 2'b01 : 2'b00;
        eb = (m_rw && m_rd == rs2) ? 2'b10 : (w_rw && w_rd == rs2) ? 2'b01 : 2'b00;
        n_checks++; if (fwd_a !== ea) begin n_fails++; $display("FAIL b2b_fwd_a i=%0d: got %b, required %b", i, fwd_a, ea); end
        n_checks++; if (fwd_b !== eb) begin n_fails++; $display("FAIL b2b_fwd_b i=%0d: got %b, required %b", i, fwd_b, eb); end
      end
      w_rw = m_rw; w_rd = m_rd;
      m_rw = rw;   m_rd = rd;
    end
    idle(4);
  endtask

  task automatic test_reset_midrun();
    drive(1'b1, C_ADD, 5'd11, 5'd1, 5'd2); cycle();
    drive(1'b1, C_ADD, 5'd12, 5'd1, 5'd2); cycle();
    drive(1'b1, C_LW,  5'd13, 5'd1, 5'd2); cycle();
    drive(1'b1, C_ADD, 5'd14, 5'd13, 5'd0);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fails++; $display("FAIL mr_stall: got %b, required 0", stall); end
    n_checks++; if ({ex_ctrl, mem_ctrl, wb_ctrl} !== 15'd0) begin n_fails++; $display("FAIL mr_ctrl: got %h %b %b, required 0", ex_ctrl, mem_ctrl, wb_ctrl); end
    n_checks++; if ({ex_rd, mem_rd, wb_rd} !== 15'd0) begin n_fails++; $display("FAIL mr_rd: got %0d %0d %0d, required 0", ex_rd, mem_rd, wb_rd); end
    n_checks++; if ({fwd_a, fwd_b} !== 4'd0) begin n_fails++; $display("FAIL mr_fwd: got %b %b, required 00 00", fwd_a, fwd_b); end
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b1, C_ADD, 5'd15, 5'd1, 5'd2);
    push(C_ADD, 5'd15);
    cycle();
    n_checks++; if (ex_ctrl !== 9'h102 || ex_rd !== 5'd15) begin n_fails++; $display("FAIL mr_first_ex: got %h rd %0d, required 102 rd 15", ex_ctrl, ex_rd); end
    idle(5);
  endtask

  initial begin
    test_reset();
    test_flow();
    test_load_use();
    test_fwd_priority();
    test_store();
    test_flush_hazard();
    test_x0();
    test_back_to_back();
    test_reset_midrun();
    n_checks++;
    if (sb.size() != 0) begin
      n_fails++;
      $display("FAIL sb_drain: %0d entries left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
